uart_regfile_top: RTL and testbench

//  Board-level top: receives 8N1 UART bytes on rx and stores each valid byte in an
//  8-entry x 8-bit register file at an auto-incrementing write pointer. dip selects

---
 rtl/uart_regfile_pkg.sv | 13 +
 rtl/uart_regfile_if.sv | 9 +
 rtl/uart_regfile_top_rx.sv | 101 ++++++++++
 rtl/uart_regfile_top.sv | 51 +++++
 tb/tb_uart_regfile_top.sv | 138 +++++++++++++
 5 files changed

// File: rtl/uart_regfile_pkg.sv
// Shared defaults and receiver state encoding for the UART register-file board top.
package uart_regfile_pkg;
  localparam int CLKS_PER_BIT_DEF = 10416;
  localparam int DEPTH_DEF        = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;
endpackage

// File: rtl/uart_regfile_if.sv
// Pin-level bundle: dip switches and UART rx in, LEDs out.
interface uart_regfile_if;
  logic [3:0] dip;
  logic       rx;
  logic [7:0] led;

  modport master (output dip, output rx, input led);
  modport slave  (input dip, input rx, output led);
endinterface

// File: rtl/uart_regfile_top_rx.sv
// 8N1 UART receiver with 2-FF input synchroniser; emits one-cycle byte and framing-error pulses.
//  state     | meaning
//  IDLE      | line idle, waiting for a falling edge
//  START     | timing to the middle of the start bit
//  DATA      | sampling 8 data bits mid-bit, LSB first
//  STOP      | sampling the stop bit
//  WAIT_IDLE | bad stop bit seen, waiting for the line to go high again
module uart_rx
  import uart_regfile_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          rx_s;

  assign rx_s       = sync_q[1];
  assign rx_data_o  = data_q;
  assign rx_valid_o = valid_q;
  assign rx_ferr_o  = ferr_q;

  // Baud timer is a down-counter; each phase loads its interval and acts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            cnt_q   <= HALF_LD;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!rx_s) begin
            cnt_q   <= FULL_LD;
            idx_q   <= '0;
            state_q <= DATA;
          end else begin
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q[idx_q] <= rx_s;
            cnt_q          <= FULL_LD;
            if (idx_q == 3'd7) state_q <= STOP;
            else               idx_q   <= idx_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rx_s) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            ferr_q  <= 1'b1;
            state_q <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_regfile_top.sv
// Board top: stores received UART bytes in a circular register file and shows one entry
// (or the status word) on the LEDs.
module uart_regfile_top
  import uart_regfile_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DEPTH        = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  uart_regfile_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    regs_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic          frame_err_q;
  logic [7:0]    led_q;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (bus.rx),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ferr_o  (rx_ferr)
  );

  // The LED register reads the pre-write contents, so a same-cycle write shows one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      wr_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      led_q       <= '0;
    end else begin
      if (rx_valid) begin
        regs_q[wr_ptr_q] <= rx_data;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (rx_ferr) frame_err_q <= 1'b1;
      if (bus.dip[3]) led_q <= {frame_err_q, 4'b0000, wr_ptr_q};
      else            led_q <= regs_q[bus.dip[2:0]];
    end
  end

  assign bus.led = led_q;
endmodule

// File: tb/tb_uart_regfile_top.sv
// Directed bench for uart_regfile_top with a shortened bit time; a monitor checks LED
// values against a queue of expectations pushed by the stimulus.
module tb_uart_regfile_top;
  localparam int CPB = 32;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  exp_t cur;
  int   tests_run = 0;
  int   fails     = 0;

  uart_regfile_if bus ();

  uart_regfile_top #(.CLKS_PER_BIT(CPB), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      wait_cycles(CPB);
    end
    bus.rx = stop_bit;
    wait_cycles(CPB);
    bus.rx = 1'b1;
  endtask

  // Apply dip, let the LED register take it on the next edge, then queue the expectation.
  task automatic expect_led(input string name, input logic [3:0] d, input logic [7:0] e);
    exp_t x;
    @(negedge clk);
    bus.dip = d;
    @(posedge clk);
    #1;
    x.name = name;
    x.exp  = e;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      tests_run++;
      if (bus.led !== cur.exp) begin
        fails++;
        $display("FAIL %s: led=0x%02h expected 0x%02h", cur.name, bus.led, cur.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rx  = 1'b1;
    bus.dip = 4'b0000;
    rst     = 1'b1;
    wait_cycles(10);
    expect_led("reset_led_in_reset", 4'b0000, 8'h00);
    rst = 1'b0;
    wait_cycles(2);
    expect_led("reset_status", 4'b1000, 8'h00);
    expect_led("reset_entry0", 4'b0000, 8'h00);

    send_frame(8'h45, 1'b1);
    wait_cycles(4);
    expect_led("byte1_entry0", 4'b0000, 8'h45);
    expect_led("byte1_status", 4'b1000, 8'h01);

    wait_cycles(20 * CPB);
    send_frame(8'hD6, 1'b1);
    wait_cycles(4);
    expect_led("byte2_entry1", 4'b0001, 8'hD6);
    expect_led("byte2_entry0", 4'b0000, 8'h45);
    expect_led("byte2_status", 4'b1000, 8'h02);

    send_frame(8'h3C, 1'b0);
    wait_cycles(3 * CPB);
    expect_led("ferr_status", 4'b1000, 8'h82);
    expect_led("ferr_no_write", 4'b0010, 8'h00);
    send_frame(8'h11, 1'b1);
    wait_cycles(4);
    expect_led("after_ferr_entry2", 4'b0010, 8'h11);
    expect_led("after_ferr_status", 4'b1000, 8'h83);

    bus.rx = 1'b0;
    wait_cycles(6);
    bus.rx = 1'b1;
    wait_cycles(3 * CPB);
    expect_led("glitch_status", 4'b1000, 8'h83);
    expect_led("glitch_entry3", 4'b0011, 8'h00);

    bus.rx = 1'b0;
    wait_cycles(3 * CPB);
    rst = 1'b1;
    wait_cycles(10);
    bus.rx = 1'b1;
    rst    = 1'b0;
    wait_cycles(12 * CPB);
    expect_led("midreset_status", 4'b1000, 8'h00);
    expect_led("midreset_entry0", 4'b0000, 8'h00);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    wait_cycles(4);
    expect_led("wrap_entry0", 4'b0000, 8'h09);
    expect_led("wrap_entry1", 4'b0001, 8'h02);
    expect_led("wrap_entry7", 4'b0111, 8'h08);
    expect_led("wrap_status", 4'b1000, 8'h01);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
